// File: rtl/prog_sequencer.sv
// prog_sequencer: steps the fetch stage through NUM_PROGS back-to-back
// programs. Each program gets an Init pulse of INIT_CYCLES cycles, then runs
// until the fetch stage raises DONE or the run length hits TIMEOUT. The run
// length of every program is measured, and programs that never finish are
// flagged.
//
// Start/finish protocol with the fetch stage: Init_out high holds the fetch
// stage in its start state. Init_out low lets it run. Done_in is a level.
// A program completes only on a high Done_in that follows at least one low
// Done_in cycle seen in the same run, so a DONE left high by the previous
// program is never mistaken for completion.

module prog_sequencer #(
  parameter int          NUM_PROGS   = 3,
  parameter int          INIT_CYCLES = 2,
  parameter logic [15:0] TIMEOUT     = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Go,
  input  logic        Done_in,
  output logic        Init_out,
  output logic [1:0]  Prog_idx,
  output logic        Busy,
  output logic        All_done,
  output logic [15:0] Cycle_count,
  output logic [15:0] Last_count,
  output logic [3:0]  Timeout_flags,
  output logic [2:0]  Dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_RUN    = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [1:0]  LAST_IDX  = 2'(NUM_PROGS - 1);

  state_t      state;
  logic [15:0] init_cnt;
  logic        armed;

  // Sequencer FSM: state, program index, run counter, arm bit and flags.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state         <= S_IDLE;
      Prog_idx      <= 2'd0;
      Cycle_count   <= 16'd0;
      Last_count    <= 16'd0;
      Timeout_flags <= 4'd0;
      init_cnt      <= 16'd0;
      armed         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FINISH: begin
          if (Go) begin
            state         <= S_INIT;
            Prog_idx      <= 2'd0;
            Timeout_flags <= 4'd0;
            Cycle_count   <= 16'd0;
            init_cnt      <= 16'd0;
          end
        end
        S_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state       <= S_RUN;
            Cycle_count <= 16'd0;
            armed       <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 16'd1;
          end
        end
        S_RUN: begin
          if (Cycle_count != 16'hFFFF) begin
            Cycle_count <= Cycle_count + 16'd1;
          end
          if (!Done_in) begin
            armed <= 1'b1;
          end
          // Completion takes priority over a timeout in the same cycle.
          if (armed && Done_in) begin
            state <= S_NEXT;
          end else if (Cycle_count == TIMEOUT) begin
            state                   <= S_NEXT;
            Timeout_flags[Prog_idx] <= 1'b1;
          end
        end
        S_NEXT: begin
          Last_count <= Cycle_count;
          if (Prog_idx == LAST_IDX) begin
            state <= S_FINISH;
          end else begin
            state    <= S_INIT;
            Prog_idx <= Prog_idx + 2'd1;
            init_cnt <= 16'd0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    Init_out  = (state != S_RUN);
    Busy      = (state == S_INIT) || (state == S_RUN) || (state == S_NEXT);
    All_done  = (state == S_FINISH);
    Dbg_state = state;
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer. Three instances share the clock and reset:
//   d=0: NUM_PROGS=1, TIMEOUT=16'hFFFF  (basic single run)
//   d=1: NUM_PROGS=3, TIMEOUT=20        (sticky done, toggling done, Go, reset)
//   d=2: NUM_PROGS=1, TIMEOUT=5         (completion vs timeout boundary)
// Inputs change and outputs are sampled on the falling edge.

module tb_prog_sequencer;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_NEXT   = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  go;
  logic [2:0]  done;
  logic [2:0]  init_o;
  logic [2:0]  busy_o;
  logic [2:0]  alld_o;
  logic [1:0]  idx_o  [3];
  logic [15:0] cyc_o  [3];
  logic [15:0] last_o [3];
  logic [3:0]  flg_o  [3];
  logic [2:0]  st_o   [3];

  int n_total = 0;
  int n_bad   = 0;

  // Expected Last_count values, consumed in program order.
  logic [15:0] exp_q[$];

  prog_sequencer #(.NUM_PROGS(1), .INIT_CYCLES(2), .TIMEOUT(16'hFFFF)) u_dut0 (
    .CLK(clk), .Reset(rst), .Go(go[0]), .Done_in(done[0]),
    .Init_out(init_o[0]), .Prog_idx(idx_o[0]), .Busy(busy_o[0]),
    .All_done(alld_o[0]), .Cycle_count(cyc_o[0]), .Last_count(last_o[0]),
    .Timeout_flags(flg_o[0]), .Dbg_state(st_o[0])
  );

  prog_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(2), .TIMEOUT(16'd20)) u_dut1 (
    .CLK(clk), .Reset(rst), .Go(go[1]), .Done_in(done[1]),
    .Init_out(init_o[1]), .Prog_idx(idx_o[1]), .Busy(busy_o[1]),
    .All_done(alld_o[1]), .Cycle_count(cyc_o[1]), .Last_count(last_o[1]),
    .Timeout_flags(flg_o[1]), .Dbg_state(st_o[1])
  );

  prog_sequencer #(.NUM_PROGS(1), .INIT_CYCLES(2), .TIMEOUT(16'd5)) u_dut2 (
    .CLK(clk), .Reset(rst), .Go(go[2]), .Done_in(done[2]),
    .Init_out(init_o[2]), .Prog_idx(idx_o[2]), .Busy(busy_o[2]),
    .All_done(alld_o[2]), .Cycle_count(cyc_o[2]), .Last_count(last_o[2]),
    .Timeout_flags(flg_o[2]), .Dbg_state(st_o[2])
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_go(input int d);
    go[d] = 1'b1;
    @(negedge clk);
    go[d] = 1'b0;
  endtask

  task automatic wait_st(input int d, input logic [2:0] st, input int budget);
    int n = 0;
    while (st_o[d] !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_state_d%0d", d), 32'(st_o[d]), 32'(st));
  endtask

  // One program: Done_in low for n_low RUN cycles, then high until NEXT.
  task automatic run_one(input int d, input int n_low);
    logic [15:0] exp;
    wait_st(d, ST_RUN, 40);
    chk($sformatf("run_entry_cyc_d%0d", d), 32'(cyc_o[d]), 32'd0);
    done[d] = 1'b0;
    repeat (n_low) @(negedge clk);
    chk($sformatf("run_cyc_d%0d", d), 32'(cyc_o[d]), 32'(n_low));
    done[d] = 1'b1;
    @(negedge clk);
    chk($sformatf("next_state_d%0d", d), 32'(st_o[d]), 32'(ST_NEXT));
    chk($sformatf("next_init_d%0d", d), 32'(init_o[d]), 32'd1);
    exp = exp_q.pop_front();
    @(negedge clk);
    chk($sformatf("last_count_d%0d", d), 32'(last_o[d]), 32'(exp));
    done[d] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    go   = 3'b000;
    done = 3'b000;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_state", 32'(st_o[d]), 32'(ST_IDLE));
      chk("rst_init",  32'(init_o[d]), 32'd1);
      chk("rst_busy",  32'(busy_o[d]), 32'd0);
      chk("rst_alld",  32'(alld_o[d]), 32'd0);
      chk("rst_idx",   32'(idx_o[d]), 32'd0);
      chk("rst_cyc",   32'(cyc_o[d]), 32'd0);
      chk("rst_last",  32'(last_o[d]), 32'd0);
      chk("rst_flags", 32'(flg_o[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic single program: INIT lasts 2 cycles, Done after 10 low cycles.
    pulse_go(0);
    chk("a_init1_state", 32'(st_o[0]), 32'(ST_INIT));
    chk("a_init1_out",   32'(init_o[0]), 32'd1);
    chk("a_init1_busy",  32'(busy_o[0]), 32'd1);
    @(negedge clk);
    chk("a_init2_state", 32'(st_o[0]), 32'(ST_INIT));
    chk("a_init2_out",   32'(init_o[0]), 32'd1);
    @(negedge clk);
    chk("a_run_state",   32'(st_o[0]), 32'(ST_RUN));
    chk("a_run_init",    32'(init_o[0]), 32'd0);
    exp_q.push_back(16'd11);
    run_one(0, 10);
    chk("a_alld",  32'(alld_o[0]), 32'd1);
    chk("a_busy",  32'(busy_o[0]), 32'd0);
    chk("a_flags", 32'(flg_o[0]), 32'd0);

    // Completion on the exact cycle Cycle_count equals TIMEOUT (5).
    exp_q.push_back(16'd6);
    pulse_go(2);
    run_one(2, 5);
    chk("c_tie_flags", 32'(flg_o[2]), 32'd0);
    chk("c_tie_alld",  32'(alld_o[2]), 32'd1);
    // Pure timeout: Done_in never rises.
    pulse_go(2);
    wait_st(2, ST_RUN, 10);
    wait_st(2, ST_NEXT, 20);
    chk("c_to_cyc", 32'(cyc_o[2]), 32'd6);
    @(negedge clk);
    chk("c_to_last",  32'(last_o[2]), 32'd6);
    chk("c_to_flags", 32'(flg_o[2]), 32'b0001);
    chk("c_to_state", 32'(st_o[2]), 32'(ST_FINISH));

    // Sticky done across three programs, TIMEOUT=20.
    pulse_go(1);
    wait_st(1, ST_RUN, 10);
    repeat (5) @(negedge clk);
    done[1] = 1'b1;
    wait_st(1, ST_NEXT, 5);
    @(negedge clk);
    chk("b_p0_last",  32'(last_o[1]), 32'd6);
    chk("b_p0_idx",   32'(idx_o[1]), 32'd1);
    chk("b_p0_state", 32'(st_o[1]), 32'(ST_INIT));
    wait_st(1, ST_NEXT, 40);
    chk("b_p1_cyc",   32'(cyc_o[1]), 32'd21);
    chk("b_p1_flags", 32'(flg_o[1]), 32'b0010);
    @(negedge clk);
    chk("b_p1_last",  32'(last_o[1]), 32'd21);
    chk("b_p1_idx",   32'(idx_o[1]), 32'd2);
    wait_st(1, ST_NEXT, 40);
    @(negedge clk);
    chk("b_fin_state", 32'(st_o[1]), 32'(ST_FINISH));
    chk("b_fin_flags", 32'(flg_o[1]), 32'b0110);
    chk("b_fin_idx",   32'(idx_o[1]), 32'd2);
    chk("b_fin_alld",  32'(alld_o[1]), 32'd1);
    chk("b_fin_busy",  32'(busy_o[1]), 32'd0);

    // Go in FINISH restarts from program 0 with flags cleared.
    done[1] = 1'b0;
    pulse_go(1);
    chk("g_restart_state", 32'(st_o[1]), 32'(ST_INIT));
    chk("g_restart_idx",   32'(idx_o[1]), 32'd0);
    chk("g_restart_flags", 32'(flg_o[1]), 32'd0);
    chk("g_restart_alld",  32'(alld_o[1]), 32'd0);

    // Done toggling per program: rises after 3, 7 and 12 RUN cycles.
    exp_q.push_back(16'd4);
    exp_q.push_back(16'd8);
    exp_q.push_back(16'd13);
    run_one(1, 3);
    chk("t_idx1", 32'(idx_o[1]), 32'd1);
    run_one(1, 7);
    chk("t_idx2", 32'(idx_o[1]), 32'd2);
    run_one(1, 12);
    chk("t_state", 32'(st_o[1]), 32'(ST_FINISH));
    chk("t_flags", 32'(flg_o[1]), 32'd0);

    // Go during RUN is ignored, then Reset mid-run of program 1.
    pulse_go(1);
    exp_q.push_back(16'd3);
    run_one(1, 2);
    wait_st(1, ST_RUN, 10);
    repeat (3) @(negedge clk);
    pulse_go(1);
    chk("g_run_state", 32'(st_o[1]), 32'(ST_RUN));
    chk("g_run_idx",   32'(idx_o[1]), 32'd1);
    chk("g_run_cyc",   32'(cyc_o[1]), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_state", 32'(st_o[1]), 32'(ST_IDLE));
    chk("r_init",  32'(init_o[1]), 32'd1);
    chk("r_idx",   32'(idx_o[1]), 32'd0);
    chk("r_cyc",   32'(cyc_o[1]), 32'd0);
    chk("r_last",  32'(last_o[1]), 32'd0);
    chk("r_flags", 32'(flg_o[1]), 32'd0);
    chk("r_busy",  32'(busy_o[1]), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program-launch controller sitting on the opposite side of the fetch stage's start/finish interface. It drives the fetch stage's `Init` input and consumes its `DONE` flag, stepping the core through `NUM_PROGS` back-to-back programs. For each program it measures the run length in cycles and flags any program that never finishes. It is used both in the top level and as the bench driver for multi-program runs.

## Interface

**Parameters**
- `NUM_PROGS`, default 3: number of programs run per `Go`; must be 1–4.
- `INIT_CYCLES`, default 2: cycles `Init_out` is held high in `INIT`; must be ≥1.
- `TIMEOUT`, default 16'hFFFF: run-cycle limit per program.

**Ports**
- `CLK`, in, 1: clock; all state changes on the rising edge only.
- `Reset`, in, 1: synchronous, active-high reset.
- `Go`, in, 1: start request; sampled in `IDLE` and `FINISH` only.
- `Done_in`, in, 1: fetch-stage `DONE`; treated as a level.
- `Init_out`, out, 1: drives the fetch-stage `Init`.
- `Prog_idx`, out, 2: index of the current or last program.
- `Busy`, out, 1: high in `INIT`, `RUN` and `NEXT`.
- `All_done`, out, 1: high in `FINISH`.
- `Cycle_count`, out, 16: run cycles of the current program.
- `Last_count`, out, 16: `Cycle_count` latched at the end of the most recent program.
- `Timeout_flags`, out, 4: bit i set if program i timed out.

## Operation

**States:** `IDLE`, `INIT`, `RUN`, `NEXT`, `FINISH`.

**Reset.** `Reset` overrides everything, including mid-run. It forces:
- state `IDLE`;
- `Init_out`=1, `Prog_idx`=0, `Busy`=0, `All_done`=0;
- `Cycle_count`=0, `Last_count`=0, `Timeout_flags`=0.

**`IDLE`**
- `Init_out`=1.
- `Go`=1 → `INIT`; `Prog_idx`=0; `Timeout_flags` cleared; `Cycle_count` cleared.

**`INIT`**
- `Init_out`=1.
- Internal counter runs for `INIT_CYCLES` cycles, then → `RUN`.
- `Done_in` is ignored.
- Entering `RUN` clears `Cycle_count` and the arm bit.

**`RUN`**
- `Init_out`=0.
- `Cycle_count` increments every cycle, saturating at 16'hFFFF.
- Arm bit sets on any `RUN` cycle with `Done_in`=0.
- Completion: arm bit (registered value) =1 and `Done_in`=1 → `NEXT`.
- A sticky-high `Done_in` carried over from the previous program therefore never completes a program.
- Timeout: `Cycle_count`==`TIMEOUT` without completion → `NEXT`; `Timeout_flags[Prog_idx]` set.
- If completion and timeout occur in the same cycle, completion wins and no flag is set.

**`NEXT`** (one cycle)
- `Init_out`=1.
- `Last_count` ← `Cycle_count`.
- If `Prog_idx`==`NUM_PROGS`-1 → `FINISH`.
- Otherwise `Prog_idx`+1 → `INIT`.

**`FINISH`**
- `Init_out`=1, `All_done`=1.
- `Prog_idx` holds the last index.
- `Go`=1 → `INIT` with the same clears as from `IDLE`.

**Other rules**
- `Go` in `INIT`, `RUN` or `NEXT` is ignored.
- `Prog_idx` never exceeds `NUM_PROGS`-1.

## Timing

- `Go` high at edge k → state `INIT` from k+1.
- `Init_out` stays high through the `INIT_CYCLES` `INIT` cycles, then falls at the edge entering `RUN`.
- `Cycle_count` reads 1 after the first `RUN` edge.
- Completion sampled at edge m → `NEXT` from m+1:
  - `Init_out`=1 combinationally from the state;
  - `Last_count` valid from edge m+2;
  - next `INIT` begins at m+2.
- Per-program overhead outside `RUN`: `INIT_CYCLES`+1 cycles.
- All outputs are registered or decoded from state; no input-to-output combinational path.

## Test plan

- **Basic run, one program.** `NUM_PROGS`=1, `INIT_CYCLES`=2. `Go`; `Done_in` low for 10 `RUN` cycles then high. Expect:
  - `Init_out` high 2 cycles after `IDLE`;
  - `Last_count`=11;
  - `All_done`=1, `Busy`=0.
- **Sticky done, three programs.** `Done_in` rises after 5 `RUN` cycles and stays high. Expect:
  - program 0 completes;
  - programs 1 and 2 run to `TIMEOUT` (set to 20);
  - `Timeout_flags`=4'b0110, `Prog_idx`=2.
- **Done toggling per program.** `Done_in` drops during each `INIT` and rises after 3, 7 and 12 `RUN` cycles. Expect:
  - `Last_count` sequence 4, 8, 13;
  - `Timeout_flags`=0.
- **Same-cycle completion and timeout.** `TIMEOUT`=5; `Done_in` armed and high exactly when `Cycle_count`=5. Expect no timeout flag.
- **Reset mid-run.** `Reset` pulse during `RUN` of program 1. Expect:
  - next cycle: `IDLE`, `Init_out`=1, `Prog_idx`=0;
  - all counters and flags 0.
- **Go handling.** `Go` pulsed during `RUN`: no effect. `Go` in `FINISH`: restart from program 0 with flags cleared.
